// File: rtl/muldiv_sched_if.sv
// Bus between the EX-stage mul/div scheduler and its pipeline, multiplier pair and divider.
interface muldiv_sched_if;
  logic        flushE;
  logic        flush_exceptionM;
  logic        stallM;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic        mult_ce_s;
  logic        mult_ce_u;
  logic        mult_sclr;
  logic [63:0] mult_p_s;
  logic [63:0] mult_p_u;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_sign;
  logic        div_opn_valid;
  logic        div_abort;
  logic        div_res_valid;
  logic [63:0] div_result;
  logic        div_res_ready;
  logic        stallE;
  logic        res_valid;
  logic [63:0] result;

  // Pipeline plus the arithmetic units, i.e. everything around the scheduler.
  modport master (
    output flushE, flush_exceptionM, stallM, op_valid, op_code, src_a, src_b,
    output mult_p_s, mult_p_u, div_res_valid, div_result,
    input  mult_a, mult_b, mult_ce_s, mult_ce_u, mult_sclr,
    input  div_a, div_b, div_sign, div_opn_valid, div_abort, div_res_ready,
    input  stallE, res_valid, result
  );

  modport slave (
    input  flushE, flush_exceptionM, stallM, op_valid, op_code, src_a, src_b,
    input  mult_p_s, mult_p_u, div_res_valid, div_result,
    output mult_a, mult_b, mult_ce_s, mult_ce_u, mult_sclr,
    output div_a, div_b, div_sign, div_opn_valid, div_abort, div_res_ready,
    output stallE, res_valid, result
  );
endinterface

// File: rtl/muldiv_sched.sv
// EX-stage multiply/divide scheduler: sequences the fixed-latency multipliers or the
// handshaked divider, stalls EX, and holds the {HI,LO} result until M accepts it.
module muldiv_sched #(
  parameter int unsigned MULT_LAT = 9
) (
  input logic           clk,
  input logic           rst,
  muldiv_sched_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(MULT_LAT) + 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic            uns_q;
  logic [63:0]     result_q;

  logic flush;
  logic live;
  logic mul_last;

  assign flush    = bus_io.flushE | bus_io.flush_exceptionM;
  assign live     = ~rst & ~flush;
  assign mul_last = (cnt_q == CntW'(MULT_LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      uns_q    <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.op_valid) begin
            a_q     <= bus_io.src_a;
            b_q     <= bus_io.src_b;
            uns_q   <= bus_io.op_code[0];
            cnt_q   <= '0;
            state_q <= bus_io.op_code[1] ? StDiv : StMul;
          end
        end
        StMul: begin
          if (mul_last) begin
            result_q <= uns_q ? bus_io.mult_p_u : bus_io.mult_p_s;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDiv: begin
          if (bus_io.div_res_valid) begin
            result_q <= bus_io.div_result;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (!bus_io.stallM) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.mult_a = a_q;
  assign bus_io.mult_b = b_q;
  assign bus_io.div_a  = a_q;
  assign bus_io.div_b  = b_q;
  assign bus_io.result = result_q;

  // A flush cycle kills every request/valid and clears the units; reset forces all to 0.
  always_comb begin
    bus_io.stallE        = ~rst & bus_io.op_valid & (state_q != StDone) &
                           ~bus_io.flush_exceptionM;
    bus_io.mult_sclr     = ~rst & flush;
    bus_io.div_abort     = ~rst & flush & (state_q == StDiv);
    bus_io.mult_ce_s     = live & (state_q == StMul) & ~uns_q;
    bus_io.mult_ce_u     = live & (state_q == StMul) & uns_q;
    bus_io.div_opn_valid = live & (state_q == StDiv);
    bus_io.div_sign      = live & (state_q == StDiv) & ~uns_q;
    bus_io.div_res_ready = live & (state_q == StDiv) & bus_io.div_res_valid;
    bus_io.res_valid     = live & (state_q == StDone);
  end

`ifndef SYNTHESIS
  op_valid_held_a: assert property (@(posedge clk) disable iff (rst)
    ((state_q == StMul || state_q == StDiv) && !flush) |-> bus_io.op_valid)
    else $error("op_valid dropped during a multi-cycle mul/div op");
`endif

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized bench for muldiv_sched with behavioural multiplier/divider models.
module tb_muldiv_sched;

  localparam int unsigned MULT_LAT = 9;
  localparam int unsigned DIV_LAT  = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [63:0] last_result = '0;
  int   div_cnt;

  muldiv_sched_if bus ();

  muldiv_sched #(.MULT_LAT(MULT_LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] div_core(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    longint q;
    longint r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'd0, a}) / longint'({32'd0, b});
      r = longint'({32'd0, a}) % longint'({32'd0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint p;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'b01:   return {32'd0, a} * {32'd0, b};
      2'b10:   return div_core(a, b, 1'b1);
      default: return div_core(a, b, 1'b0);
    endcase
  endfunction

  // Multiplier pair: product presented combinationally from the latched operands.
  always_comb begin
    bus.mult_p_s = 64'(longint'($signed(bus.mult_a)) * longint'($signed(bus.mult_b)));
    bus.mult_p_u = {32'd0, bus.mult_a} * {32'd0, bus.mult_b};
  end

  // Divider: DIV_LAT cycles of request, then result held until consumed or aborted.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt           <= 0;
      bus.div_res_valid <= 1'b0;
      bus.div_result    <= '0;
    end else if (bus.div_abort) begin
      div_cnt           <= 0;
      bus.div_res_valid <= 1'b0;
    end else if (bus.div_res_valid) begin
      if (bus.div_res_ready) bus.div_res_valid <= 1'b0;
    end else if (bus.div_opn_valid) begin
      if (div_cnt == DIV_LAT - 1) begin
        div_cnt           <= 0;
        bus.div_res_valid <= 1'b1;
        bus.div_result    <= div_core(bus.div_a, bus.div_b, bus.div_sign);
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end
  end

  task automatic test_reset();
    bus.flushE = 0; bus.flush_exceptionM = 0; bus.stallM = 0; bus.op_valid = 0;
    bus.op_code = 0; bus.src_a = 0; bus.src_b = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({bus.stallE, bus.res_valid, bus.mult_ce_s, bus.mult_ce_u, bus.mult_sclr, bus.div_sign,
         bus.div_opn_valid, bus.div_abort, bus.div_res_ready} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0", {bus.stallE, bus.res_valid, bus.mult_ce_s,
               bus.mult_ce_u, bus.mult_sclr, bus.div_sign, bus.div_opn_valid, bus.div_abort,
               bus.div_res_ready});
    end
    vectors++;
    if ({bus.result, bus.mult_a, bus.mult_b, bus.div_a, bus.div_b} !== 192'd0) begin
      miscompares++;
      $display("FAIL reset_data got result=%h a=%h b=%h want 0", bus.result, bus.mult_a,
               bus.mult_b);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if ({bus.stallE, bus.res_valid, bus.mult_ce_s, bus.div_opn_valid} !== 4'd0) begin
      miscompares++;
      $display("FAIL post_reset_idle got %b want 0", {bus.stallE, bus.res_valid,
               bus.mult_ce_s, bus.div_opn_valid});
    end
  endtask

  // Entered just after a negedge with the DUT in IDLE; leaves it in IDLE the same way.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string name);
    logic [63:0] exp;
    int stalls, ready_pulses, exp_stalls;
    bit done, bad_path, bad_opnd;
    exp        = ref_result(op, a, b);
    exp_stalls = op[1] ? DIV_LAT + 2 : MULT_LAT + 1;
    bus.op_valid = 1; bus.op_code = op; bus.src_a = a; bus.src_b = b; bus.stallM = (hold > 0);
    stalls = 0; ready_pulses = 0; done = 0; bad_path = 0; bad_opnd = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      if (bus.res_valid) begin
        done = 1;
      end else begin
        if (bus.stallE) stalls++;
        if (bus.div_res_ready) ready_pulses++;
        if (cyc > 0) begin
          if ((op[1] ? {bus.div_a, bus.div_b} : {bus.mult_a, bus.mult_b}) !== {a, b})
            bad_opnd = 1;
          case (op)
            2'b00: if ({bus.mult_ce_s, bus.mult_ce_u, bus.div_opn_valid} !== 3'b100) bad_path = 1;
            2'b01: if ({bus.mult_ce_s, bus.mult_ce_u, bus.div_opn_valid} !== 3'b010) bad_path = 1;
            default: if ({bus.mult_ce_s, bus.mult_ce_u, bus.div_opn_valid, bus.div_sign} !==
                         {3'b001, ~op[0]}) bad_path = 1;
          endcase
        end
        @(negedge clk);
        bus.src_a = $urandom;
        bus.src_b = $urandom;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s timeout got no res_valid want res_valid within 200 cycles", name);
    end
    vectors++;
    if (bus.result !== exp) begin
      miscompares++;
      $display("FAIL %s result got %h want %h", name, bus.result, exp);
    end
    vectors++;
    if (stalls != exp_stalls) begin
      miscompares++;
      $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, exp_stalls);
    end
    vectors++;
    if (bus.stallE !== 1'b0) begin
      miscompares++;
      $display("FAIL %s stallE_in_done got %b want 0", name, bus.stallE);
    end
    vectors++;
    if (ready_pulses != (op[1] ? 1 : 0)) begin
      miscompares++;
      $display("FAIL %s div_res_ready_pulses got %0d want %0d", name, ready_pulses, op[1]);
    end
    vectors++;
    if (bad_path || bad_opnd) begin
      miscompares++;
      $display("FAIL %s unit_select got bad_path=%b bad_operand=%b want 0 0", name, bad_path,
               bad_opnd);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == hold - 1) bus.stallM = 0;
      #1;
      vectors++;
      if ({bus.res_valid, bus.result} !== {1'b1, exp}) begin
        miscompares++;
        $display("FAIL %s hold%0d got valid=%b result=%h want 1 %h", name, h, bus.res_valid,
                 bus.result, exp);
      end
    end
    @(negedge clk);
    bus.op_valid = 0;
    #1;
    vectors++;
    if (bus.res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release got res_valid=%b want 0", name, bus.res_valid);
    end
    last_result = exp;
  endtask

  task automatic test_directed();
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, "mult_neg3x5");
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, "multu_max_x2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 3, "div_neg7_2_hold3");
    run_op(2'b11, 32'd10, 32'd3, 0, "divu_10_3_b2b");
    run_op(2'b11, 32'hDEAD_BEEF, 32'd0, 1, "divu_by_zero");
  endtask

  task automatic test_flush_idle();
    bus.op_valid = 1; bus.op_code = 2'b00; bus.src_a = 32'd7; bus.src_b = 32'd9;
    bus.flushE = 1;
    @(negedge clk);
    bus.flushE = 0; bus.op_valid = 0;
    #1;
    vectors++;
    if ({bus.mult_ce_s, bus.mult_ce_u, bus.div_opn_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL flush_idle_accept got ce/valid=%b want 000", {bus.mult_ce_s,
               bus.mult_ce_u, bus.div_opn_valid});
    end
  endtask

  task automatic test_flush_mul();
    bit seen_valid;
    bus.op_valid = 1; bus.op_code = 2'b00; bus.src_a = $urandom; bus.src_b = $urandom;
    bus.stallM = 0;
    @(negedge clk);
    repeat (4) @(negedge clk);
    bus.flushE = 1;
    #1;
    vectors++;
    if ({bus.mult_sclr, bus.mult_ce_s, bus.res_valid, bus.div_abort} !== 4'b1000) begin
      miscompares++;
      $display("FAIL flush_mul_cycle got sclr/ce/valid/abort=%b want 1000", {bus.mult_sclr,
               bus.mult_ce_s, bus.res_valid, bus.div_abort});
    end
    @(negedge clk);
    bus.flushE = 0; bus.op_valid = 0;
    #1;
    vectors++;
    if ({bus.mult_sclr, bus.stallE, bus.mult_ce_s, bus.result} !== {3'b000, last_result}) begin
      miscompares++;
      $display("FAIL flush_mul_idle got sclr/stall/ce=%b result=%h want 000 %h",
               {bus.mult_sclr, bus.stallE, bus.mult_ce_s}, bus.result, last_result);
    end
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (bus.res_valid) seen_valid = 1;
    end
    vectors++;
    if (seen_valid) begin
      miscompares++;
      $display("FAIL flush_mul_no_result got res_valid=1 want 0");
    end
    run_op(2'b00, 32'd2, 32'd3, 0, "mult_2x3_after_flush");
  endtask

  task automatic test_flush_exc_div();
    bit hit;
    bus.op_valid = 1; bus.op_code = 2'b10; bus.src_a = $urandom; bus.src_b = $urandom_range(1, 99);
    @(negedge clk);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (bus.div_res_valid) hit = 1;
      else @(negedge clk);
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL flush_exc_wait got no div_res_valid want div_res_valid within 100");
    end
    bus.flush_exceptionM = 1;
    #1;
    vectors++;
    if ({bus.stallE, bus.div_abort, bus.div_res_ready, bus.res_valid, bus.mult_sclr,
         bus.div_opn_valid} !== 6'b010010) begin
      miscompares++;
      $display("FAIL flush_exc_cycle got stall/abort/ready/valid/sclr/opn=%b want 010010",
               {bus.stallE, bus.div_abort, bus.div_res_ready, bus.res_valid, bus.mult_sclr,
                bus.div_opn_valid});
    end
    @(negedge clk);
    bus.flush_exceptionM = 0; bus.op_valid = 0;
    #1;
    vectors++;
    if ({bus.res_valid, bus.stallE, bus.div_opn_valid, bus.result} !==
        {3'b000, last_result}) begin
      miscompares++;
      $display("FAIL flush_exc_idle got valid/stall/opn=%b result=%h want 000 %h",
               {bus.res_valid, bus.stallE, bus.div_opn_valid}, bus.result, last_result);
    end
  endtask

  task automatic test_reset_mid_div();
    bus.op_valid = 1; bus.op_code = 2'b11; bus.src_a = $urandom; bus.src_b = $urandom;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.stallE, bus.res_valid, bus.mult_ce_s, bus.mult_ce_u, bus.mult_sclr, bus.div_sign,
         bus.div_opn_valid, bus.div_abort, bus.div_res_ready, bus.result, bus.div_a,
         bus.div_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_div got ctrl=%b result=%h div_a=%h want all 0",
               {bus.stallE, bus.res_valid, bus.mult_ce_s, bus.mult_ce_u, bus.mult_sclr,
                bus.div_sign, bus.div_opn_valid, bus.div_abort, bus.div_res_ready},
               bus.result, bus.div_a);
    end
    bus.op_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    last_result = '0;
    @(negedge clk);
    run_op(2'b11, 32'd100, 32'd7, 0, "divu_after_reset");
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) a = -a;
      run_op(op, a, b, $urandom_range(0, 3), "random_op");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush_idle();
    test_flush_mul();
    test_flush_exc_div();
    test_reset_mid_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multiply/divide scheduler for the EX stage. Accepts MULT/MULTU/DIV/DIVU requests from the ALU decode, latches the operands, and sequences the shared fixed-latency multiplier pair (signed/unsigned, clock-enabled, SCLR) or the handshaked radix-2 divider. It produces the EX stall and a 64-bit {HI,LO} result, then holds that result until the M stage accepts it. It aborts cleanly on pipeline flush.

## Interface
- `MULT_LAT`, default 9: multiplier latency in cycles of CE-high before P is valid.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flushE` in 1: flush of the EX instruction; aborts the operation.
- `flush_exceptionM` in 1: exception flush; aborts the operation and masks stall.
- `stallM` in 1: M stage stalled; the result cannot yet leave EX.
- `op_valid` in 1: EX holds a mul/div op; held high while EX is stalled.
- `op_code` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`, `src_b` in 32: operands; sampled only on accept.
- `mult_a`, `mult_b` out 32: latched operands to both multipliers.
- `mult_ce_s`, `mult_ce_u` out 1: CE to the signed/unsigned multiplier.
- `mult_sclr` out 1: synchronous clear to both multipliers.
- `mult_p_s`, `mult_p_u` in 64: multiplier products.
- `div_a`, `div_b` out 32: latched dividend and divisor.
- `div_sign` out 1: 1 = signed divide.
- `div_opn_valid` out 1: divide request.
- `div_abort` out 1: divider reset pulse.
- `div_res_valid` in 1: divider result valid.
- `div_result` in 64: {remainder, quotient}.
- `div_res_ready` out 1: divider result consumed.
- `stallE` out 1: stall EX and the earlier stages.
- `res_valid` out 1: `result` is valid for the op in EX.
- `result` out 64: {HI, LO}.

## Operation
- States are IDLE, MUL, DIV, DONE. Reset enters IDLE. On reset all outputs are 0, operand/result registers are 0, and the counter is 0.
- IDLE, `op_valid` high and no flush: latch `src_a`/`src_b`, `op_code[0]` (unsigned flag) and `op_code[1]` (div flag). Go to MUL (clear counter) or to DIV.
- MUL:
  - Assert `mult_ce_s` if the op is signed, otherwise `mult_ce_u`.
  - The counter increments each cycle.
  - In the cycle where counter == MULT_LAT-1, capture `mult_p_s` or `mult_p_u` into `result` at the edge and go to DONE.
- DIV:
  - `div_opn_valid` = 1. `div_sign` = ~unsigned flag.
  - On `div_res_valid`, capture `div_result` and go to DONE. `div_res_ready` pulses 1 in that cycle.
- DONE:
  - `res_valid` = 1. Stay while `stallM` = 1.
  - When `stallM` = 0, go to IDLE; the op advances to M at that edge.
- `stallE` = `op_valid` & (state != DONE) & ~`flush_exceptionM`. This is combinational and is high in the accept cycle.
- Flush: `flushE` or `flush_exceptionM` in any state forces IDLE at the next edge.
  - In that cycle `mult_sclr` = 1, and `div_abort` = 1 if the state is DIV.
  - In that cycle `res_valid` and all CE/valid outputs are 0.
  - A flush in IDLE suppresses accept.
- Captured operands stay stable from accept until IDLE re-entry, independent of `src_*` (forwarding may change them).
- Divide-by-zero needs no special case: the divider's output is passed through unchanged.
- `op_valid` falling in MUL/DIV without a flush is illegal. Assert it in simulation only.

## Timing
- MULT/MULTU: accept at edge 0. `result` is valid, `res_valid` = 1 and `stallE` = 0 after edge MULT_LAT, i.e. MULT_LAT+1 stalled cycles including the accept cycle.
- DIV/DIVU: `res_valid` rises at the edge after the cycle with `div_res_valid`. Latency is divider latency + 1.
- Back-to-back ops: DONE→IDLE edge, then the next op is accepted the following cycle. There is one IDLE bubble cycle between ops.
- Reset mid-MUL/DIV: immediate IDLE, outputs 0, no `div_abort` pulse (the divider is reset by `rst` externally).
- `flushE` and `div_res_valid` in the same cycle: flush wins, the result is discarded.
- Counter width is ceil(log2(MULT_LAT))+1. It never wraps because it stops at MULT_LAT-1.

## Test plan
- MULT: -3 × 5 → after 9 stall cycles following accept, `result` = 64'hFFFF_FFFF_FFFF_FFF1 and `res_valid` = 1. `mult_ce_u` is never high.
- MULTU: 0xFFFFFFFF × 2 → `result` = 64'h0000_0001_FFFF_FFFE. `stallE` is high for exactly 10 cycles including the accept cycle.
- DIV with a modelled 34-cycle divider: -7 / 2 → `div_result` {32'hFFFF_FFFF, 32'hFFFF_FFFD} is captured. `div_res_ready` pulses once. `div_sign` = 1 throughout.
- DONE with `stallM` held 3 cycles → `result` and `res_valid` are held. Then IDLE, and a following DIVU 10/3 accepted the next cycle → `result` = {1, 3}.
- `flushE` in MUL at counter 4 → `mult_sclr` = 1 for 1 cycle, IDLE next cycle, `stallE` = 0, no `res_valid`. A fresh MULT 2×3 then yields 6 after the full latency.
- `flush_exceptionM` coinciding with `div_res_valid` → `stallE` is 0 in that cycle, `div_abort` = 1, IDLE next cycle, `result` register unchanged. Async `rst` mid-DIV → all outputs 0 immediately.
